// File: rtl/rom_arb_pkg.sv
// Shared definitions for the instruction-ROM arbiter: port ids, word size and
// the registered response record.
package rom_arb_pkg;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_LD = 1'b1;

  localparam int unsigned WORD_BYTES = 4;

  typedef struct packed {
    logic valid;
    logic port;
    logic err;
  } resp_t;

endpackage

// File: rtl/rom_arb_starve_cnt.sv
// Saturating count of consecutive IF losses; max_o tells the arbiter to let
// IF through on the next contended cycle.
module rom_arb_starve_cnt
  import rom_arb_pkg::*;
#(
  parameter int unsigned MAX = 4,
  parameter int unsigned W   = $clog2(MAX + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc_i,
  input  logic clr_i,
  output logic max_o
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != MAX_V)) begin
      cnt_d = cnt_q + W'(1);
    end
    max_o = (cnt_q == MAX_V);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rom_arbiter.sv
// Shares the single ROM read port between instruction fetch and loads; loads
// win by default, starved fetches are forced through, IF responses squashable.
module rom_arbiter
  import rom_arb_pkg::*;
#(
  parameter int unsigned ROM_AW     = 5,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [31:0]       if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [31:0]       if_rdata_o,
  output logic              if_err_o,
  input  logic              ld_req_i,
  input  logic [31:0]       ld_addr_i,
  output logic              ld_gnt_o,
  output logic              ld_rvalid_o,
  output logic [31:0]       ld_rdata_o,
  output logic              ld_err_o,
  input  logic              flush_i,
  output logic              rom_en_o,
  output logic [ROM_AW-1:0] rom_addr_o,
  input  logic [31:0]       rom_data_i
);

  localparam int unsigned OFS = $clog2(WORD_BYTES);

  logic        starve_max;
  logic        if_ok, if_gnt, ld_gnt, any_gnt, addr_err;
  logic        if_resp, ld_resp;
  logic [31:0] sel_addr;
  resp_t       resp_d, resp_q;

  always_comb begin
    // Grants are gated by rst so every output reads 0 while held in reset.
    if_ok    = rst & if_req_i & ~flush_i;
    ld_gnt   = rst & ld_req_i & ~(if_ok & starve_max);
    if_gnt   = if_ok & ~ld_gnt;
    any_gnt  = if_gnt | ld_gnt;

    sel_addr = ld_gnt ? ld_addr_i : if_addr_i;
    addr_err = (|sel_addr[OFS-1:0]) | (|sel_addr[31:ROM_AW+OFS]);

    if_gnt_o   = if_gnt;
    ld_gnt_o   = ld_gnt;
    rom_en_o   = any_gnt & ~addr_err;
    rom_addr_o = any_gnt ? sel_addr[ROM_AW+OFS-1:OFS] : '0;

    resp_d = '{valid: any_gnt,
               port:  (ld_gnt ? PORT_LD : PORT_IF),
               err:   any_gnt & addr_err};

    // A flush in the response cycle drops a pending fetch; loads always land.
    if_resp = resp_q.valid & (resp_q.port == PORT_IF) & ~flush_i;
    ld_resp = resp_q.valid & (resp_q.port == PORT_LD);

    if_rvalid_o = if_resp;
    if_err_o    = if_resp & resp_q.err;
    if_rdata_o  = (if_resp & ~resp_q.err) ? rom_data_i : '0;
    ld_rvalid_o = ld_resp;
    ld_err_o    = ld_resp & resp_q.err;
    ld_rdata_o  = (ld_resp & ~resp_q.err) ? rom_data_i : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_q <= '0;
    end else begin
      resp_q <= resp_d;
    end
  end

  rom_arb_starve_cnt #(
    .MAX (STARVE_MAX)
  ) u_starve (
    .clk   (clk),
    .rst_n (rst),
    .inc_i (if_req_i & ld_gnt),
    .clr_i (if_gnt | ~if_req_i),
    .max_o (starve_max)
  );

endmodule

// File: tb/tb_rom_arbiter.sv
// Self-checking bench for rom_arbiter: directed vector table, hand-written
// corner sequences and random traffic against a behavioural reference model.
module tb_rom_arbiter;

  localparam int unsigned ROM_AW     = 5;
  localparam int unsigned STARVE_MAX = 4;
  localparam int unsigned DEPTH      = 1 << ROM_AW;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req_i, ld_req_i, flush_i;
  logic [31:0]       if_addr_i, ld_addr_i;
  logic              if_gnt_o, if_rvalid_o, if_err_o;
  logic              ld_gnt_o, ld_rvalid_o, ld_err_o;
  logic [31:0]       if_rdata_o, ld_rdata_o;
  logic              rom_en_o;
  logic [ROM_AW-1:0] rom_addr_o;
  logic [31:0]       rom_data_i;

  logic [31:0] mem [DEPTH];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: pending response and IF loss streak.
  int unsigned m_cnt;
  bit          p_valid, p_port, p_err;
  int unsigned p_word;

  // Outputs sampled by the last step.
  logic        s_if_gnt, s_ld_gnt, s_rom_en;
  logic [31:0] s_rom_addr, s_if_rvalid, s_ld_rvalid;

  always #5 clk = ~clk;

  rom_arbiter #(
    .ROM_AW     (ROM_AW),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .if_req_i    (if_req_i),
    .if_addr_i   (if_addr_i),
    .if_gnt_o    (if_gnt_o),
    .if_rvalid_o (if_rvalid_o),
    .if_rdata_o  (if_rdata_o),
    .if_err_o    (if_err_o),
    .ld_req_i    (ld_req_i),
    .ld_addr_i   (ld_addr_i),
    .ld_gnt_o    (ld_gnt_o),
    .ld_rvalid_o (ld_rvalid_o),
    .ld_rdata_o  (ld_rdata_o),
    .ld_err_o    (ld_err_o),
    .flush_i     (flush_i),
    .rom_en_o    (rom_en_o),
    .rom_addr_o  (rom_addr_o),
    .rom_data_i  (rom_data_i)
  );

  // Behavioural one-cycle-latency ROM.
  always @(posedge clk) begin
    if (rom_en_o) rom_data_i <= mem[rom_addr_o];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt   = 0;
    p_valid = 0;
    p_port  = 0;
    p_err   = 0;
    p_word  = 0;
  endtask

  // One clock cycle: drive, compare every output with the model, advance model.
  task automatic step(input bit ir, input logic [31:0] ia, input bit lr,
                      input logic [31:0] la, input bit fl);
    bit          e_if, e_ld, bad, e_ifv, e_ldv;
    logic [31:0] a, e_data;
    int unsigned word;
    @(negedge clk);
    if_req_i  = ir;
    if_addr_i = ia;
    ld_req_i  = lr;
    ld_addr_i = la;
    flush_i   = fl;
    #1;
    e_if   = ir && !fl && (!lr || m_cnt == STARVE_MAX);
    e_ld   = lr && !e_if;
    a      = e_ld ? la : ia;
    bad    = (a % 4 != 0) || ((a >> (ROM_AW + 2)) != 0);
    word   = (a / 4) % DEPTH;
    e_ifv  = p_valid && (p_port == 0) && !fl;
    e_ldv  = p_valid && (p_port == 1);
    e_data = p_err ? 32'h0 : mem[p_word];

    chk("if_gnt",    32'(if_gnt_o), 32'(e_if));
    chk("ld_gnt",    32'(ld_gnt_o), 32'(e_ld));
    chk("rom_en",    32'(rom_en_o), 32'((e_if || e_ld) && !bad));
    chk("rom_addr",  32'(rom_addr_o), (e_if || e_ld) ? 32'(word) : 32'h0);
    chk("if_rvalid", 32'(if_rvalid_o), 32'(e_ifv));
    chk("if_err",    32'(if_err_o), 32'(e_ifv && p_err));
    chk("if_rdata",  if_rdata_o, e_ifv ? e_data : 32'h0);
    chk("ld_rvalid", 32'(ld_rvalid_o), 32'(e_ldv));
    chk("ld_err",    32'(ld_err_o), 32'(e_ldv && p_err));
    chk("ld_rdata",  ld_rdata_o, e_ldv ? e_data : 32'h0);
    chk("starve_cnt", 32'(dut.u_starve.cnt_q), 32'(m_cnt));

    s_if_gnt    = if_gnt_o;
    s_ld_gnt    = ld_gnt_o;
    s_rom_en    = rom_en_o;
    s_rom_addr  = 32'(rom_addr_o);
    s_if_rvalid = 32'(if_rvalid_o);
    s_ld_rvalid = 32'(ld_rvalid_o);

    @(posedge clk);
    p_valid = e_if || e_ld;
    p_port  = e_ld;
    p_err   = bad;
    p_word  = word;
    if (!ir || e_if) m_cnt = 0;
    else if (e_ld && m_cnt < STARVE_MAX) m_cnt++;
  endtask

  typedef struct {
    bit          ir;
    logic [31:0] ia;
    bit          lr;
    logic [31:0] la;
    bit          fl;
    bit          e_if;
    bit          e_ld;
    bit          e_en;
    logic [31:0] e_ra;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(bit ir, logic [31:0] ia, bit lr, logic [31:0] la, bit fl,
                              bit e_if, bit e_ld, bit e_en, logic [31:0] e_ra);
    vec_t v;
    v = '{ir, ia, lr, la, fl, e_if, e_ld, e_en, e_ra};
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = 32'hA500_0000 ^ (32'(i) * 32'h0101_0101);
    mem[2] = 32'h2401_0005;

    rst = 1'b0;
    if_req_i = 0; ld_req_i = 0; flush_i = 0;
    if_addr_i = '0; ld_addr_i = '0;
    model_reset();
    #13;
    chk("reset_if_gnt",   32'(if_gnt_o), 32'h0);
    chk("reset_rom_en",   32'(rom_en_o), 32'h0);
    chk("reset_rom_addr", 32'(rom_addr_o), 32'h0);
    chk("reset_ld_rvalid", 32'(ld_rvalid_o), 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Contention/starvation, flush interaction and address errors.
    for (int i = 0; i < 4; i++) vt.push_back(mk(1, 32'h0, 1, 32'h4, 0, 0, 1, 1, 1));
    vt.push_back(mk(1, 32'h0, 1, 32'h4, 0, 1, 0, 1, 0));
    vt.push_back(mk(1, 32'h0, 1, 32'h4, 0, 0, 1, 1, 1));
    for (int i = 0; i < 3; i++) vt.push_back(mk(1, 32'h0, 1, 32'h4, 0, 0, 1, 1, 1));
    vt.push_back(mk(1, 32'h0, 1, 32'h8, 1, 0, 1, 1, 2));
    vt.push_back(mk(1, 32'hC, 1, 32'h8, 0, 1, 0, 1, 3));
    vt.push_back(mk(0, 32'h0, 1, 32'h10, 1, 0, 1, 1, 4));
    vt.push_back(mk(1, 32'h8, 0, 32'h0, 0, 1, 0, 1, 2));
    vt.push_back(mk(0, 32'h0, 0, 32'h0, 0, 0, 0, 0, 0));
    vt.push_back(mk(0, 32'h0, 1, 32'h6, 0, 0, 1, 0, 1));
    vt.push_back(mk(0, 32'h0, 1, 32'h100, 0, 0, 1, 0, 0));
    vt.push_back(mk(0, 32'h0, 0, 32'h0, 0, 0, 0, 0, 0));
    foreach (vt[i]) begin
      step(vt[i].ir, vt[i].ia, vt[i].lr, vt[i].la, vt[i].fl);
      chk($sformatf("vec%0d_if_gnt", i), 32'(s_if_gnt), 32'(vt[i].e_if));
      chk($sformatf("vec%0d_ld_gnt", i), 32'(s_ld_gnt), 32'(vt[i].e_ld));
      chk($sformatf("vec%0d_rom_en", i), 32'(s_rom_en), 32'(vt[i].e_en));
      chk($sformatf("vec%0d_rom_addr", i), s_rom_addr, vt[i].e_ra);
    end

    // IF response squashed by flush; the load granted alongside still lands.
    step(1, 32'h8, 0, 32'h0, 0);
    step(0, 32'h0, 1, 32'hC, 1);
    chk("squash_if_rvalid", s_if_rvalid, 32'h0);
    step(0, 32'h0, 0, 32'h0, 0);
    chk("post_squash_ld_rvalid", s_ld_rvalid, 32'h1);

    // Alternating single requests.
    step(1, 32'h0, 0, 32'h0, 0);
    step(0, 32'h0, 1, 32'h4, 0);
    step(1, 32'h8, 0, 32'h0, 0);
    step(0, 32'h0, 0, 32'h0, 0);

    // Reset mid-cycle while a load response is being presented.
    step(0, 32'h0, 1, 32'h10, 0);
    if_req_i = 1; ld_req_i = 1; ld_addr_i = 32'h4;
    #2;
    rst = 1'b0;
    #1;
    chk("rst_if_gnt",    32'(if_gnt_o), 32'h0);
    chk("rst_ld_gnt",    32'(ld_gnt_o), 32'h0);
    chk("rst_rom_en",    32'(rom_en_o), 32'h0);
    chk("rst_rom_addr",  32'(rom_addr_o), 32'h0);
    chk("rst_ld_rvalid", 32'(ld_rvalid_o), 32'h0);
    chk("rst_ld_rdata",  ld_rdata_o, 32'h0);
    if_req_i = 0; ld_req_i = 0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    step(1, 32'h8, 0, 32'h0, 0);
    step(0, 32'h0, 0, 32'h0, 0);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] ia, la;
      int unsigned r;
      r  = $urandom_range(0, 9);
      ia = (r == 0) ? $urandom : (32'($urandom_range(0, DEPTH - 1)) << 2) | ((r == 1) ? 32'h2 : 32'h0);
      r  = $urandom_range(0, 9);
      la = (r == 0) ? $urandom : (32'($urandom_range(0, DEPTH - 1)) << 2) | ((r == 1) ? 32'h1 : 32'h0);
      step(bit'($urandom_range(0, 3) != 0), ia, bit'($urandom_range(0, 1)), la,
           bit'($urandom_range(0, 4) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
